// File: rtl/mul_serial_unit_if.sv
// rtl/mul_serial_unit_if.sv - dispatch-side and result-side handshake bundle for mul_serial_unit
interface mul_serial_unit_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_packet;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/mul_serial_unit.sv
// rtl/mul_serial_unit.sv - iterative shift-and-add unsigned multiplier, WIDTH steps per product
module mul_serial_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  mul_serial_unit_if.slave  bus,
  output logic              busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [2*WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      count;
  logic               last_step;

  assign acc_step  = multiplier[0] ? acc + multiplicand : acc;
  assign last_step = (count == CNT_LAST);

  // Handshake outputs are pure state decodes, so nothing combinational reaches them from inputs.
  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_product = product;
  assign busy            = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = BUSY;
      BUSY:    if (last_step) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      product      <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      count        <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            multiplicand <= {{WIDTH{1'b0}}, bus.in_packet[WIDTH-1:0]};
            multiplier   <= bus.in_packet[2*WIDTH-1:WIDTH];
            acc          <= '0;
            count        <= '0;
          end
        end
        BUSY: begin
          acc          <= acc_step;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          count        <= count + CNT_ONE;
          // The final step's sum goes straight to the output register.
          if (last_step) product <= acc_step;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_serial_unit.sv
// tb/tb_mul_serial_unit.sv - directed and randomized checks of mul_serial_unit against arithmetic products
module tb_mul_serial_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_serial_unit_if #(.WIDTH(W)) bus ();

  mul_serial_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Presents a packet, returns once the accepting edge has passed.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_packet = {b, a};
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("accept_timeout", 64'(guard < 200), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  logic [63:0] exp_q[$];
  logic [31:0] sa, sb;
  logic [63:0] held;
  int          lat;
  int          got;
  int          sent;
  int          budget;
  bit          seen_valid;
  bit          stable;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", bus.out_product, 64'd0);
    rst = 1'b0;
    tick();

    // Basic latency 3*5
    bus.out_ready = 1'b1;
    send(32'd3, 32'd5);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_in_busy", 64'(bus.in_ready), 64'd0);
    wait_valid(lat);
    check("basic_latency", 64'(lat), 64'd32);
    check("basic_product", bus.out_product, 64'h0000_0000_0000_000F);
    tick();
    check("basic_out_valid_drop", 64'(bus.out_valid), 64'd0);
    check("basic_in_ready_after", 64'(bus.in_ready), 64'd1);

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("max_product", bus.out_product, 64'hFFFF_FFFE_0000_0001);
    tick();

    send(32'hFFFF_FFFF, 32'd7);
    wait_valid(lat);
    check("signed_low_half", 64'(bus.out_product[31:0]), 64'h0000_0000_FFFF_FFF9);
    tick();

    send(32'd0, 32'h1234);
    wait_valid(lat);
    check("zero_latency", 64'(lat), 64'd32);
    check("zero_product", bus.out_product, 64'd0);
    tick();

    // Back-pressure with a pending 2*2
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_1001);
    wait_valid(lat);
    held = bus.out_product;
    check("bp_product", held, ref_mul(32'hDEAD_BEEF, 32'h0000_1001));
    bus.in_valid  = 1'b1;
    bus.in_packet = {32'd2, 32'd2};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.out_product !== held || bus.in_ready) stable = 1'b0;
    end
    check("bp_stable_window", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_after_handshake", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_pending_accepted", 64'(busy), 64'd1);
    wait_valid(lat);
    check("bp_pending_latency", 64'(lat), 64'd32);
    check("bp_pending_product", bus.out_product, 64'd4);
    tick();

    // Reset at BUSY cycle 12 of 7*9
    send(32'd7, 32'd9);
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      tick();
    end
    check("midreset_no_output", 64'(seen_valid), 64'd0);
    send(32'd6, 32'd7);
    wait_valid(lat);
    check("post_reset_latency", 64'(lat), 64'd32);
    check("post_reset_product", bus.out_product, 64'd42);
    tick();

    // Random stream with gaps on both sides
    got = 0;
    sent = 0;
    budget = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    while (got < 16 && budget < 5000) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("stream_extra_output", 64'd1, 64'd0);
        else check("stream_product", bus.out_product, exp_q.pop_front());
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mul(sa, sb));
        sent++;
      end
      tick();
      budget++;
      if (bus.in_valid && sent > 0 && exp_q.size() > 0 && !bus.in_ready && busy) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < 16 && !busy && $urandom_range(0, 2) != 0) begin
        sa = $urandom();
        sb = $urandom();
        bus.in_packet = {sb, sa};
        bus.in_valid  = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    check("stream_count", 64'(got), 64'd16);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
